// File: rtl/sprite_line_mapper.sv
// Per-scanline sprite mapper: a blanking-time scan builds a slot set for the next line,
// and a registered lookup resolves the highest-priority sprite under DrawX from that set.
module sprite_line_mapper #(
    parameter int NUM_SPRITES  = 16,
    parameter int MAX_PER_LINE = 8,
    parameter int SIZE_LOG2    = 5,
    parameter int COORD_W      = 10,
    parameter int ID_W         = 4
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           eval_start,
    input  logic [COORD_W-1:0]             eval_y,
    input  logic [COORD_W-1:0]             DrawX,
    input  logic [NUM_SPRITES*COORD_W-1:0] PosX_flat,
    input  logic [NUM_SPRITES*COORD_W-1:0] PosY_flat,
    input  logic [NUM_SPRITES*ID_W-1:0]    ID_flat,
    output logic [ID_W-1:0]                spriteIDOut,
    output logic [SIZE_LOG2-1:0]           sPosXOut,
    output logic [SIZE_LOG2-1:0]           sPosYOut,
    output logic                           eval_busy,
    output logic                           line_overflow
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
    localparam logic [ID_W-1:0]    TRANSP   = '1;
    localparam logic [COORD_W:0]   SPAN     = (COORD_W+1)'(2 ** SIZE_LOG2);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(MAX_PER_LINE);

    typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

    state_t state, next_state;

    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [COORD_W-1:0] line_y;
    logic               ovf_pend;

    logic                 sh_valid  [MAX_PER_LINE];
    logic [COORD_W-1:0]   sh_x      [MAX_PER_LINE];
    logic [ID_W-1:0]      sh_id     [MAX_PER_LINE];
    logic [SIZE_LOG2-1:0] sh_row    [MAX_PER_LINE];
    logic                 act_valid [MAX_PER_LINE];
    logic [COORD_W-1:0]   act_x     [MAX_PER_LINE];
    logic [ID_W-1:0]      act_id    [MAX_PER_LINE];
    logic [SIZE_LOG2-1:0] act_row   [MAX_PER_LINE];

    logic [COORD_W-1:0]   cur_x, cur_y;
    logic [ID_W-1:0]      cur_id;
    logic [COORD_W:0]     dy, dx;
    logic                 cur_hit;
    logic [ID_W-1:0]      win_id;
    logic [SIZE_LOG2-1:0] win_sx, win_sy;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (eval_start) next_state = SCAN;
            SCAN:    if (idx == LAST_IDX) next_state = SWAP;
            SWAP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign eval_busy = (state != IDLE);

    always_comb begin
        cur_x  = '0;
        cur_y  = '0;
        cur_id = TRANSP;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_x  = PosX_flat[i*COORD_W +: COORD_W];
                cur_y  = PosY_flat[i*COORD_W +: COORD_W];
                cur_id = ID_flat[i*ID_W +: ID_W];
            end
        end
    end

    // Extra top bit catches line_y < PosY as a borrow, so positions never wrap onto low lines
    assign dy      = {1'b0, line_y} - {1'b0, cur_y};
    assign cur_hit = (cur_id != TRANSP) && !dy[COORD_W] && (dy < SPAN);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx           <= '0;
            cnt           <= '0;
            line_y        <= '0;
            ovf_pend      <= 1'b0;
            line_overflow <= 1'b0;
            for (int s = 0; s < MAX_PER_LINE; s++) begin
                sh_valid[s]  <= 1'b0;
                act_valid[s] <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (eval_start) begin
                        line_y   <= eval_y;
                        idx      <= '0;
                        cnt      <= '0;
                        ovf_pend <= 1'b0;
                        for (int s = 0; s < MAX_PER_LINE; s++) sh_valid[s] <= 1'b0;
                    end
                end
                SCAN: begin
                    // Slots fill in table order, so slot index doubles as priority
                    if (cur_hit) begin
                        if (cnt < FULL_CNT) begin
                            for (int s = 0; s < MAX_PER_LINE; s++) begin
                                if (cnt == CNT_W'(s)) begin
                                    sh_valid[s] <= 1'b1;
                                    sh_x[s]     <= cur_x;
                                    sh_id[s]    <= cur_id;
                                    sh_row[s]   <= dy[SIZE_LOG2-1:0];
                                end
                            end
                            cnt <= cnt + CNT_W'(1);
                        end else begin
                            ovf_pend <= 1'b1;
                        end
                    end
                    idx <= idx + IDX_W'(1);
                end
                SWAP: begin
                    for (int s = 0; s < MAX_PER_LINE; s++) begin
                        act_valid[s] <= sh_valid[s];
                        act_x[s]     <= sh_x[s];
                        act_id[s]    <= sh_id[s];
                        act_row[s]   <= sh_row[s];
                    end
                    line_overflow <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

    // Walk slots high to low so the lowest-index hit is the one left standing
    always_comb begin
        win_id = TRANSP;
        win_sx = '0;
        win_sy = '0;
        dx     = '0;
        for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
            dx = {1'b0, DrawX} - {1'b0, act_x[s]};
            if (act_valid[s] && !dx[COORD_W] && (dx < SPAN)) begin
                win_id = act_id[s];
                win_sx = dx[SIZE_LOG2-1:0];
                win_sy = act_row[s];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            spriteIDOut <= TRANSP;
            sPosXOut    <= '0;
            sPosYOut    <= '0;
        end else begin
            spriteIDOut <= win_id;
            sPosXOut    <= win_sx;
            sPosYOut    <= win_sy;
        end
    end

endmodule

// File: tb/tb_sprite_line_mapper.sv
// Scoreboard bench for sprite_line_mapper: scans, lookups, overflow, boundaries and resets.
module tb_sprite_line_mapper;

    localparam int NS = 16;
    localparam int CW = 10;
    localparam int IW = 4;
    localparam int SL = 5;
    localparam int CW11 = 11;

    logic clk = 1'b0;
    logic reset;
    logic evalStart;
    logic [CW-1:0] evalY, drawX;
    logic [NS*CW-1:0] posXFlat, posYFlat;
    logic [NS*IW-1:0] idFlat;
    logic [IW-1:0] spriteId;
    logic [SL-1:0] sPosX, sPosY;
    logic busy, overflow;

    logic evalStart11;
    logic [CW11-1:0] evalY11, drawX11;
    logic [NS*CW11-1:0] posXFlat11, posYFlat11;
    logic [NS*IW-1:0] idFlat11;
    logic [IW-1:0] spriteId11;
    logic [SL-1:0] sPosX11, sPosY11;
    logic busy11, overflow11;

    logic [CW-1:0] posX [NS];
    logic [CW-1:0] posY [NS];
    logic [IW-1:0] ids  [NS];

    typedef struct {
        logic [IW-1:0] id;
        logic [SL-1:0] sx;
        logic [SL-1:0] sy;
    } exp_t;
    exp_t expQ[$];

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    always_comb begin
        posXFlat = '0;
        posYFlat = '0;
        idFlat   = '0;
        for (int i = 0; i < NS; i++) begin
            posXFlat[i*CW +: CW] = posX[i];
            posYFlat[i*CW +: CW] = posY[i];
            idFlat[i*IW +: IW]   = ids[i];
        end
    end

    sprite_line_mapper dut (
        .Clk(clk), .Reset(reset), .eval_start(evalStart), .eval_y(evalY), .DrawX(drawX),
        .PosX_flat(posXFlat), .PosY_flat(posYFlat), .ID_flat(idFlat),
        .spriteIDOut(spriteId), .sPosXOut(sPosX), .sPosYOut(sPosY),
        .eval_busy(busy), .line_overflow(overflow)
    );

    sprite_line_mapper #(.COORD_W(CW11)) dut11 (
        .Clk(clk), .Reset(reset), .eval_start(evalStart11), .eval_y(evalY11), .DrawX(drawX11),
        .PosX_flat(posXFlat11), .PosY_flat(posYFlat11), .ID_flat(idFlat11),
        .spriteIDOut(spriteId11), .sPosXOut(sPosX11), .sPosYOut(sPosY11),
        .eval_busy(busy11), .line_overflow(overflow11)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vecCount++;
        if (got !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Present DrawX, queue the expectation, and compare once the registered result lands
    task automatic applyStimulus(input string tag, input int x, input int id, input int sx, input int sy);
        exp_t e;
        drawX = CW'(x);
        e.id = IW'(id);
        e.sx = SL'(sx);
        e.sy = SL'(sy);
        expQ.push_back(e);
        @(posedge clk); #1;
        e = expQ.pop_front();
        checkOutput({tag, "_id"}, 32'(spriteId), 32'(e.id));
        checkOutput({tag, "_sx"}, 32'(sPosX), 32'(e.sx));
        checkOutput({tag, "_sy"}, 32'(sPosY), 32'(e.sy));
    endtask

    task automatic runScan(input int y, input int pulseAt, input string tag);
        int n;
        evalY = CW'(y);
        evalStart = 1'b1;
        @(posedge clk); #1;
        evalStart = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            evalStart = (n == pulseAt);
            @(posedge clk); #1;
        end
        evalStart = 1'b0;
        checkOutput({tag, "_busy_len"}, 32'(n), 32'd17);
    endtask

    task automatic clearTable();
        for (int i = 0; i < NS; i++) begin
            posX[i] = '0;
            posY[i] = '0;
            ids[i]  = '1;
        end
    endtask

    task automatic scan11(input int y, input int wantId, input int wantSy, input string tag);
        int n;
        evalY11 = CW11'(y);
        evalStart11 = 1'b1;
        @(posedge clk); #1;
        evalStart11 = 1'b0;
        n = 0;
        while (busy11 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        checkOutput({tag, "_busy_len"}, 32'(n), 32'd17);
        @(posedge clk); #1;
        checkOutput({tag, "_id"}, 32'(spriteId11), 32'(wantId));
        checkOutput({tag, "_sy"}, 32'(sPosY11), 32'(wantSy));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1;
        evalStart = 1'b0;
        evalY = '0;
        drawX = '0;
        evalStart11 = 1'b0;
        evalY11 = '0;
        drawX11 = '0;
        posXFlat11 = '0;
        posYFlat11 = '0;
        posYFlat11[0 +: CW11] = CW11'(1000);
        idFlat11 = '1;
        idFlat11[0 +: IW] = IW'(2);
        clearTable();
        posX[0] = 100; posY[0] = 50; ids[0] = 3;

        repeat (2) @(posedge clk); #1;
        checkOutput("rst_id", 32'(spriteId), 32'hF);
        checkOutput("rst_sx", 32'(sPosX), 0);
        checkOutput("rst_sy", 32'(sPosY), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;
        applyStimulus("rst_empty", 110, 15, 0, 0);

        runScan(60, 0, "basic");
        checkOutput("basic_ovf", 32'(overflow), 0);
        applyStimulus("basic_miss_left", 99, 15, 0, 0);
        applyStimulus("basic_right_edge", 131, 3, 31, 10);
        applyStimulus("basic_past_edge", 132, 15, 0, 0);
        applyStimulus("basic_hit", 110, 3, 10, 10);

        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_loaded_id", 32'(spriteId), 32'hF);
        checkOutput("rst_loaded_sx", 32'(sPosX), 0);
        checkOutput("rst_loaded_sy", 32'(sPosY), 0);
        reset = 1'b0;
        applyStimulus("rst_cleared", 110, 15, 0, 0);

        clearTable();
        posX[2] = 100; posY[2] = 60; ids[2] = 5;
        posX[7] = 100; posY[7] = 60; ids[7] = 9;
        runScan(60, 0, "overlap");
        applyStimulus("overlap_prio", 100, 5, 0, 0);
        applyStimulus("overlap_edge", 131, 5, 31, 0);

        clearTable();
        for (int i = 0; i < 10; i++) begin
            posX[i] = CW'(i * 40); posY[i] = 0; ids[i] = 1;
        end
        runScan(0, 0, "ovf");
        checkOutput("ovf_flag", 32'(overflow), 1);
        applyStimulus("ovf_slot0", 5, 1, 5, 0);
        applyStimulus("ovf_slot7", 280, 1, 0, 0);
        applyStimulus("ovf_dropped8", 330, 15, 0, 0);
        ids[8] = '1; ids[9] = '1;
        runScan(0, 0, "ovf_clear");
        checkOutput("ovf_cleared", 32'(overflow), 0);
        applyStimulus("ovf_clear_slot7", 290, 1, 10, 0);

        clearTable();
        posX[0] = 0;   posY[0] = 1000; ids[0] = 2;
        posX[1] = 200; posY[1] = 1000; ids[1] = 15;
        runScan(4, 0, "nowrap");
        applyStimulus("nowrap_x0", 0, 15, 0, 0);
        runScan(1023, 0, "bottom");
        applyStimulus("bottom_x0", 0, 2, 0, 23);
        applyStimulus("bottom_x31", 31, 2, 31, 23);
        applyStimulus("transp_skip", 210, 15, 0, 0);

        scan11(1031, 2, 31, "w11_hit");
        scan11(1032, 15, 0, "w11_miss");

        clearTable();
        posX[0] = 100; posY[0] = 50; ids[0] = 3;
        runScan(60, 5, "restart_ignored");
        applyStimulus("restart_hit", 110, 3, 10, 10);

        clearTable();
        posX[4] = 300; posY[4] = 60; ids[4] = 6;
        evalY = CW'(60);
        evalStart = 1'b1;
        @(posedge clk); #1;
        evalStart = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("midrst_busy", 32'(busy), 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("midrst_busy_later", 32'(busy), 0);
        checkOutput("midrst_ovf", 32'(overflow), 0);
        applyStimulus("midrst_old_gone", 110, 15, 0, 0);
        applyStimulus("midrst_no_swap", 310, 15, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
